// File: rtl/cpu_pkg.sv
// Shared eBPF CPU definitions used by the lddw dst-save path.
package cpu_pkg;

  localparam int          REG_ADDR_W    = 4;
  localparam logic [7:0]  LDDW_OPCODE   = 8'h18;
  localparam logic [7:0]  PSEUDO_OPCODE = 8'h00;

  typedef logic [3:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WRITE   = 2'd2
  } lddw_state_e;

endpackage

// File: rtl/lddw_assembler.sv
// Assembles the two lddw slots into one 64-bit register-file write.
// Optional LDDW_ERR_CNT_EN adds a saturating err_cnt output.
//
// state   | meaning
// IDLE    | waiting for an lddw first slot
// WAIT_HI | low imm and dst captured, waiting for the pseudo slot
// WRITE   | holding the 64-bit write request until wr_ready
module lddw_assembler
  import cpu_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int          IMM_W       = 32,
  parameter int          REG_ADDR_W  = 4,
  parameter logic [7:0]  LDDW_OPCODE = 8'h18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  insn_valid,
  output logic                  insn_ready,
  input  logic [7:0]            insn_opcode,
  input  logic [REG_ADDR_W-1:0] insn_dst,
  input  logic [REG_ADDR_W-1:0] insn_src,
  input  logic [IMM_W-1:0]      insn_imm,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [REG_ADDR_W-1:0] wr_dst,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  lddw_err
`ifdef LDDW_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  lddw_state_e           state, state_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [IMM_W-1:0]      lo_q, lo_d;
  logic [REG_ADDR_W-1:0] wr_dst_d;
  logic [DATA_W-1:0]     wr_data_d;
  logic                  err_d;
  logic                  pseudo_ok;

  assign pseudo_ok  = (insn_opcode == PSEUDO_OPCODE) && (insn_dst == '0) && (insn_src == '0);
  assign insn_ready = (state != WRITE);
  assign wr_valid   = (state == WRITE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dst_q    <= '0;
      lo_q     <= '0;
      wr_dst   <= '0;
      wr_data  <= '0;
      lddw_err <= 1'b0;
    end else begin
      state    <= state_d;
      dst_q    <= dst_d;
      lo_q     <= lo_d;
      wr_dst   <= wr_dst_d;
      wr_data  <= wr_data_d;
      lddw_err <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    dst_d     = dst_q;
    lo_d      = lo_q;
    wr_dst_d  = wr_dst;
    wr_data_d = wr_data;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        // non-lddw slots are consumed here; the main pipeline executes them
        if (insn_valid && (insn_opcode == LDDW_OPCODE)) begin
          dst_d   = insn_dst;
          lo_d    = insn_imm;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (insn_valid) begin
          if (pseudo_ok) begin
            wr_dst_d  = dst_q;
            wr_data_d = {insn_imm, lo_q};
            state_d   = WRITE;
          end else if (insn_opcode == LDDW_OPCODE) begin
            // a fresh lddw restarts the pair from this slot
            err_d = 1'b1;
            dst_d = insn_dst;
            lo_d  = insn_imm;
          end else begin
            err_d   = 1'b1;
            dst_d   = '0;
            lo_d    = '0;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LDDW_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_d && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
